ps2_kbd_engine: RTL and testbench
=================================

# ps2_kbd_engine

Parametrised PS/2 keyboard front-end that supersedes the single-key controller feeding the seven-segment display top. It synchronises and deframes the PS/2 serial stream with parity, framing and timeout checking, and decodes make/break/extended (E0) sequences. It tracks the currently held key with typematic-repeat suppression and counts distinct presses. Press events are buffered in a valid/ready FIFO so a downstream consumer (ASCII translator, display or CPU port) can drain them without loss.

## Interface
- CNT_W, 8: width of press counter.
- FIFO_DEPTH, 8: event FIFO entries; power of 2, ≥2.
- TIMEOUT_CYC, 50000: idle clk cycles mid-frame before the frame is abandoned.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-low.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- key_code  out  8  scan code of most recent press; held after release.
- key_ext  out  1  key_code was E0-prefixed.
- is_press  out  1  key_code currently held.
- press_count  out  CNT_W  distinct press events, wraps modulo 2^CNT_W.
- ev_data  out  9  FIFO head, {ext, code}.
- ev_valid  out  1  FIFO non-empty.
- ev_ready  in  1  consumer accepts head when ev_valid & ev_ready.
- parity_err  out  1  one-cycle pulse, frame dropped on bad parity/start/stop.
- timeout_err  out  1  one-cycle pulse, partial frame abandoned.
- ev_overflow  out  1  one-cycle pulse, press event dropped because FIFO full.

## Operation
- Sync: ps2_clk and ps2_data each through 3 flops; strobe F = sync[2] & ~sync[1] (falling edge). ps2_data sampled from the matching sync stage in cycle F.
- Deframer: bit counter 0..10, 11-bit shift register, LSB first. Frame = start 0, data[7:0], odd parity, stop 1. At bit 10: if start==0, stop==1, ^{data,parity}==1, emit byte strobe; else pulse parity_err. Counter returns to 0 either way.
- Timeout: counter cleared on every F, increments while bit counter ≠ 0; reaching TIMEOUT_CYC clears bit counter and pulses timeout_err. Not active when bit counter == 0.
- Decoder FSM, states IDLE, EXT, BRK, EXT_BRK; transitions only on byte strobe:
  - IDLE: E0→EXT; F0→BRK; other → make(ext=0), stay IDLE.
  - EXT: F0→EXT_BRK; E0→EXT; other → make(ext=1), →IDLE.
  - BRK: any byte → break(code, ext=0), →IDLE.
  - EXT_BRK: any byte → break(code, ext=1), →IDLE.
- make(c,e): if is_press & key_code==c & key_ext==e → typematic repeat, no effect. Else key_code←c, key_ext←e, is_press←1, press_count+1, push {e,c}.
- break(c,e): if c,e match key_code,key_ext, is_press←0; otherwise ignored. key_code, key_ext retained.
- FIFO: circular, log2(FIFO_DEPTH)+1-bit pointers. Push when full → drop, pulse ev_overflow. Push and pop same cycle when full → both performed, no overflow. Pop when empty impossible (ev_valid=0).
- Reset: bit counter, timeout counter, FSM (IDLE), key_code, key_ext, is_press, press_count, FIFO pointers, all error pulses → 0; ev_valid=0. Reset mid-frame discards partial frame; sync flops reset to 1.

## Timing
- Pin fall to F: 3 clk cycles.
- Frame ends at F of stop bit. Byte strobe, parity_err registered at F+1.
- key_code, key_ext, is_press, press_count, FIFO write, ev_overflow updated at F+2.
- ev_valid rises at F+3 when FIFO was empty; ev_data stable while ev_valid & ~ev_ready.
- Pop: entry removed at the edge where ev_valid & ev_ready; next head/ev_valid visible the following cycle.
- timeout_err asserted the cycle after the timeout counter reaches TIMEOUT_CYC.
- Full throughput: one event per frame; FIFO accepts one push and one pop per cycle.

## Test plan
- Reset, frame 0x1C good parity → F+2: key_code=0x1C, key_ext=0, is_press=1, press_count=1; ev_data=0x01C, ev_valid=1 at F+3.
- 0x1C ×3 more, then F0 1C → press_count stays 1, one FIFO entry, is_press=0 after break, key_code=0x1C retained; F0 2A (non-matching) while 0x1C held → no change.
- E0 75, then E0 F0 75 → key_code=0x75, key_ext=1, ev_data=0x175, is_press 1 then 0; plain 75 afterwards counts as new press (count +1).
- Frame 0x1C with even parity, and frame with stop=0 → parity_err pulse each, no state/count/FIFO change; next good frame decoded normally.
- Four ps2_clk edges then silence TIMEOUT_CYC cycles → timeout_err pulse; following full frame 0x2A decoded correctly; separately rst=0 mid-frame → all outputs 0, next frame decoded.
- FIFO_DEPTH=4, CNT_W=4, ev_ready=0, 17 distinct presses → entries 1–4 kept, ev_overflow pulses on 5th–17th, press_count=1 (wrapped); drain with ev_ready=1 → four events in order, ev_valid falls after the 4th.

Source files
------------

// File: rtl/ps2_kbd_engine_if.sv
// Press-event stream between the PS/2 keyboard engine and its consumer.
// ev_data is {ext, code}; a transfer happens on a clock where ev_valid and ev_ready are both high.
interface ps2_kbd_engine_if;
   logic [8:0] ev_data;
   logic       ev_valid;
   logic       ev_ready;

   modport master (output ev_data, output ev_valid, input ev_ready);
   modport slave  (input ev_data, input ev_valid, output ev_ready);
endinterface

// File: rtl/ps2_kbd_engine.sv
// PS/2 keyboard front-end: pin synchroniser, frame checker with timeout, make/break/E0 decoder,
// held-key tracker with typematic suppression, and a press-event FIFO for the consumer.
module ps2_kbd_engine #(
   parameter int CNT_W       = 8,
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ps2_clk_i,
   input  logic                ps2_data_i,
   output logic [7:0]          key_code_o,
   output logic                key_ext_o,
   output logic                is_press_o,
   output logic [CNT_W-1:0]    press_count_o,
   output logic                parity_err_o,
   output logic                timeout_err_o,
   output logic                ev_overflow_o,
   ps2_kbd_engine_if.master    ev
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

   logic [2:0]        sclk_q, sdat_q;
   logic [3:0]        bcnt_q;
   logic [9:0]        shreg_q;
   logic [TW-1:0]     tmo_q;
   logic              byte_vld_q, perr_q, terr_q;
   logic [7:0]        byte_q;
   state_t            state_q, state_d;
   logic              do_make, do_brk, ev_ext, match, new_press;
   logic [7:0]        key_code_q;
   logic              key_ext_q, is_press_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              push_q;
   logic [8:0]        push_data_q;
   logic [8:0]        mem_q [FIFO_DEPTH];
   logic [AW:0]       wr_q, rd_q;
   logic              fall, bit_in, frame_ok, full, empty, pop, wr_en;

   // Pins are asynchronous; idle-high reset keeps a reset from faking a falling edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sclk_q <= '1;
         sdat_q <= '1;
      end else begin
         sclk_q <= {sclk_q[1:0], ps2_clk_i};
         sdat_q <= {sdat_q[1:0], ps2_data_i};
      end
   end

   assign fall     = sclk_q[2] & ~sclk_q[1];
   assign bit_in   = sdat_q[1];
   assign frame_ok = ~shreg_q[0] & bit_in & (^shreg_q[9:1]);

   always_ff @(posedge clk) begin
      if (!rst) begin
         bcnt_q     <= '0;
         tmo_q      <= '0;
         byte_vld_q <= 1'b0;
         perr_q     <= 1'b0;
         terr_q     <= 1'b0;
      end else begin
         byte_vld_q <= 1'b0;
         perr_q     <= 1'b0;
         terr_q     <= 1'b0;
         if (fall) begin
            tmo_q <= '0;
            if (bcnt_q == 4'd10) begin
               bcnt_q     <= '0;
               byte_vld_q <= frame_ok;
               perr_q     <= ~frame_ok;
            end else begin
               bcnt_q <= bcnt_q + 4'd1;
            end
         end else if (bcnt_q != 4'd0) begin
            if (tmo_q == TW'(TIMEOUT_CYC)) begin
               bcnt_q <= '0;
               tmo_q  <= '0;
               terr_q <= 1'b1;
            end else begin
               tmo_q <= tmo_q + TW'(1);
            end
         end
      end
   end

   // shreg holds start..parity, LSB first; the stop bit is checked live from bit_in.
   always_ff @(posedge clk) begin
      if (fall) shreg_q <= {bit_in, shreg_q[9:1]};
      if (fall && bcnt_q == 4'd10) byte_q <= shreg_q[8:1];
   end

   always_ff @(posedge clk) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      do_make = 1'b0;
      do_brk  = 1'b0;
      ev_ext  = 1'b0;
      if (byte_vld_q) begin
         case (state_q)
            S_IDLE: begin
               if (byte_q == 8'hE0)      state_d = S_EXT;
               else if (byte_q == 8'hF0) state_d = S_BRK;
               else                      do_make = 1'b1;
            end
            S_EXT: begin
               ev_ext = 1'b1;
               if (byte_q == 8'hF0)      state_d = S_EXT_BRK;
               else if (byte_q == 8'hE0) state_d = S_EXT;
               else begin
                  do_make = 1'b1;
                  state_d = S_IDLE;
               end
            end
            S_BRK: begin
               do_brk  = 1'b1;
               state_d = S_IDLE;
            end
            default: begin
               do_brk  = 1'b1;
               ev_ext  = 1'b1;
               state_d = S_IDLE;
            end
         endcase
      end
   end

   assign match     = is_press_q & (key_code_q == byte_q) & (key_ext_q == ev_ext);
   assign new_press = do_make & ~match;

   always_ff @(posedge clk) begin
      if (!rst) begin
         key_code_q <= '0;
         key_ext_q  <= 1'b0;
         is_press_q <= 1'b0;
         cnt_q      <= '0;
         push_q     <= 1'b0;
      end else begin
         push_q <= new_press;
         if (new_press) begin
            key_code_q <= byte_q;
            key_ext_q  <= ev_ext;
            is_press_q <= 1'b1;
            cnt_q      <= cnt_q + CNT_W'(1);
         end else if (do_brk && match) begin
            is_press_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (new_press) push_data_q <= {ev_ext, byte_q};
   end

   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop   = ~empty & ev.ev_ready;
   assign wr_en = push_q & (~full | pop);

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (wr_en) wr_q <= wr_q + (AW+1)'(1);
         if (pop)   rd_q <= rd_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_q[AW-1:0]] <= push_data_q;
   end

   assign ev.ev_data     = mem_q[rd_q[AW-1:0]];
   assign ev.ev_valid    = ~empty;
   assign ev_overflow_o  = push_q & full & ~pop;
   assign key_code_o     = key_code_q;
   assign key_ext_o      = key_ext_q;
   assign is_press_o     = is_press_q;
   assign press_count_o  = cnt_q;
   assign parity_err_o   = perr_q;
   assign timeout_err_o  = terr_q;
endmodule

// File: tb/tb_ps2_kbd_engine.sv
// Scoreboard bench for ps2_kbd_engine: a key-level model predicts press events and errors,
// and a monitor compares every FIFO transfer and error pulse the DUT produces.
module tb_ps2_kbd_engine;
   localparam int CNT_W = 4;
   localparam int DEPTH = 4;
   localparam int TMO   = 200;
   localparam int HALF  = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             ps2_clk = 1'b1;
   logic             ps2_data = 1'b1;
   logic [7:0]       key_code;
   logic             key_ext, is_press, parity_err, timeout_err, ev_overflow;
   logic [CNT_W-1:0] press_count;

   ps2_kbd_engine_if evif();

   ps2_kbd_engine #(.CNT_W(CNT_W), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
      .clk           (clk),
      .rst           (rst),
      .ps2_clk_i     (ps2_clk),
      .ps2_data_i    (ps2_data),
      .key_code_o    (key_code),
      .key_ext_o     (key_ext),
      .is_press_o    (is_press),
      .press_count_o (press_count),
      .parity_err_o  (parity_err),
      .timeout_err_o (timeout_err),
      .ev_overflow_o (ev_overflow),
      .ev            (evif)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   logic [8:0] expq [$];
   logic [7:0] m_code;
   logic       m_ext, m_held;
   int         m_count;
   bit         pe0, pf0;
   int         exp_perr = 0, exp_terr = 0, exp_ovf = 0;
   int         got_perr = 0, got_terr = 0, got_ovf = 0;
   bit         hold_phase = 0, rdy_mode = 1;
   int         hold_occ = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---- reference model: what a keyboard user would see ----
   task automatic model_reset();
      m_code = '0; m_ext = 0; m_held = 0; m_count = 0;
      pe0 = 0; pf0 = 0; hold_occ = 0;
      expq.delete();
   endtask

   task automatic model_make(input logic [7:0] b, input logic e);
      if (m_held && m_code == b && m_ext == e) return;
      m_code = b; m_ext = e; m_held = 1;
      m_count = (m_count + 1) % (1 << CNT_W);
      if (!hold_phase) expq.push_back({e, b});
      else if (hold_occ < DEPTH) begin
         hold_occ++;
         expq.push_back({e, b});
      end else exp_ovf++;
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (pf0) begin
         if (m_held && m_code == b && m_ext == pe0) m_held = 0;
         pf0 = 0; pe0 = 0;
      end else if (b == 8'hE0) pe0 = 1;
      else if (b == 8'hF0) pf0 = 1;
      else begin
         model_make(b, pe0);
         pe0 = 0;
      end
   endtask

   // ---- stimulus ----
   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = f[i];
         cyc(HALF);
         ps2_clk = 1'b0;
         cyc(HALF);
         ps2_clk = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      logic [10:0] f;
      f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      send_bits(f, 11);
      ps2_data = 1'b1;
      cyc(20);
   endtask

   task automatic send_good(input logic [7:0] b);
      model_byte(b);
      send_frame(b, 0, 0);
   endtask

   task automatic check_state();
      chk("key_code", key_code, m_code);
      chk("key_ext", key_ext, m_ext);
      chk("is_press", is_press, m_held);
      chk("press_count", press_count, m_count);
   endtask

   task automatic do_reset();
      model_reset();
      rst = 1'b0;
      cyc(3);
      chk("rst_key_code", key_code, 0);
      chk("rst_key_ext", key_ext, 0);
      chk("rst_is_press", is_press, 0);
      chk("rst_press_count", press_count, 0);
      chk("rst_ev_valid", evif.ev_valid, 0);
      chk("rst_err_pulses", {parity_err, timeout_err, ev_overflow}, 0);
      rst = 1'b1;
      cyc(2);
   endtask

   // ---- consumer and monitor ----
   initial begin
      evif.ev_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         evif.ev_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         if (parity_err)  got_perr++;
         if (timeout_err) got_terr++;
         if (ev_overflow) got_ovf++;
         if (evif.ev_valid && evif.ev_ready) begin
            if (expq.size() == 0) chk("unexpected_event", evif.ev_data, 32'hFFFF_FFFF);
            else chk("ev_data", evif.ev_data, expq.pop_front());
         end
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] codes [4];
      codes[0] = 8'h1C; codes[1] = 8'h2A; codes[2] = 8'h75; codes[3] = 8'h32;
      cyc(2);
      do_reset();

      send_good(8'h1C);
      check_state();
      repeat (3) send_good(8'h1C);
      send_good(8'hF0); send_good(8'h2A);
      check_state();
      send_good(8'hF0); send_good(8'h1C);
      check_state();

      send_good(8'hE0); send_good(8'h75);
      check_state();
      send_good(8'hE0); send_good(8'hF0); send_good(8'h75);
      check_state();
      send_good(8'h75);
      check_state();

      send_frame(8'h1C, 1, 0); exp_perr++;
      send_frame(8'h1C, 0, 1); exp_perr++;
      check_state();
      chk("parity_err_pulses", got_perr, exp_perr);
      send_good(8'h32);
      check_state();

      send_bits(11'b110_0101_0100, 4);
      ps2_data = 1'b1;
      cyc(TMO + 30);
      exp_terr++;
      chk("timeout_err_pulses", got_terr, exp_terr);
      send_good(8'h2A);
      check_state();

      send_bits(11'b110_0011_1000, 5);
      do_reset();
      send_good(8'h1C);
      check_state();

      for (int n = 0; n < 40; n++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 2) send_good(8'hE0);
         else if (r < 4) send_good(8'hF0);
         else if (r == 4) begin
            send_frame(codes[$urandom_range(0, 3)], 1, 0);
            exp_perr++;
         end else send_good(codes[$urandom_range(0, 3)]);
         check_state();
      end
      chk("parity_err_random", got_perr, exp_perr);

      for (int i = 0; i < 400 && expq.size() != 0; i++) cyc(1);
      do_reset();
      rdy_mode = 0;
      cyc(2);
      hold_phase = 1;
      for (int i = 0; i < 17; i++) send_good(8'h10 + 8'(i));
      check_state();
      chk("ev_valid_full", evif.ev_valid, 1);
      chk("overflow_pulses", got_ovf, exp_ovf);
      rdy_mode = 1;
      for (int i = 0; i < 400 && (expq.size() != 0 || evif.ev_valid); i++) cyc(1);
      hold_phase = 0;
      chk("drained_ev_valid", evif.ev_valid, 0);
      chk("queue_left", expq.size(), 0);
      chk("timeout_total", got_terr, exp_terr);
      chk("parity_total", got_perr, exp_perr);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
